miner_nonce_ctrl: RTL and testbench

- Sequencer directly upstream and downstream of the miner core control unit.
- Walks a 32-bit nonce range and pulses hash_enable to start one hash per nonce.
- On each hash completion, captures the 256-bit digest on finished and compares it against the target.
- Stops with a golden nonce on a hit, or with done when the range is exhausted; watchdogs the core for hangs.

---
 rtl/miner_nonce_ctrl.sv | 158 +++++++++++++++
 tb/tb_miner_nonce_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_nonce_ctrl.sv
// Nonce sequencer for the miner core: issues one hash per nonce over an inclusive range,
// compares each digest against the latched target and stops on a hit, exhaustion or core hang.
module miner_nonce_ctrl #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ack,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target,
    input  logic               finished,
    input  logic [HASH_W-1:0]  hash_in,
    output logic               hash_enable,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic               done,
    output logic               timeout,
    output logic [NONCE_W-1:0] attempts
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        FOUND,
        EXHAUST,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NONCE_W-1:0] end_reg;
    logic [HASH_W-1:0]  target_reg;
    logic [HASH_W-1:0]  hash_reg;
    logic [WD_W-1:0]    wd_cnt;
    logic               hit;
    logic               last;
    logic               abort_req;

    // Equality with the target counts as a miss, hence strict less-than.
    assign hit       = (hash_reg < target_reg);
    assign last      = (nonce == end_reg);
    assign abort_req = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        hash_enable = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) state_next = ISSUE;
            end
            ISSUE: begin
                hash_enable = 1'b1;
                busy        = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (finished)                state_next = CHECK;
                else if (wd_cnt == WD_LIMIT) state_next = ERROR;
            end
            CHECK: begin
                busy = 1'b1;
                if (hit)       state_next = FOUND;
                else if (last) state_next = EXHAUST;
                else           state_next = ISSUE;
            end
            FOUND, EXHAUST, ERROR: begin
                if (ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_req) state_next = IDLE;
    end

    // Datapath; abort only clears the sticky flags so nonce/attempts stay visible afterwards.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            nonce        <= '0;
            golden_nonce <= '0;
            attempts     <= '0;
            target_reg   <= '0;
            end_reg      <= '0;
            hash_reg     <= '0;
            wd_cnt       <= '0;
            found        <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else if (abort_req) begin
            found   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        nonce      <= nonce_start;
                        end_reg    <= nonce_end;
                        target_reg <= target;
                        attempts   <= '0;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (finished) begin
                        hash_reg <= hash_in;
                        attempts <= attempts + NONCE_W'(1);
                    end else if (wd_cnt == WD_LIMIT) begin
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                CHECK: begin
                    if (hit) begin
                        golden_nonce <= nonce;
                        found        <= 1'b1;
                    end else if (last) begin
                        done <= 1'b1;
                    end else begin
                        nonce <= nonce + NONCE_W'(1);
                    end
                end
                FOUND, EXHAUST, ERROR: begin
                    if (ack) begin
                        found   <= 1'b0;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_nonce_ctrl.sv
// Scoreboard bench for miner_nonce_ctrl: a reference search model fills expected queues,
// a core model answers hash requests, and a monitor checks every pulse and result.
module tb_miner_nonce_ctrl;

    localparam int NW = 32;
    localparam int HW = 256;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic          ack;
    logic [NW-1:0] nonce_start;
    logic [NW-1:0] nonce_end;
    logic [HW-1:0] target;
    logic          finished;
    logic [HW-1:0] hash_in;
    logic          hash_enable;
    logic [NW-1:0] nonce;
    logic          busy;
    logic          found;
    logic [NW-1:0] golden_nonce;
    logic          done;
    logic          timeout;
    logic [NW-1:0] attempts;

    logic          core_fin;
    logic [HW-1:0] core_hash;
    logic          man_fin;
    logic [HW-1:0] man_hash;

    assign finished = core_fin | man_fin;
    assign hash_in  = man_fin ? man_hash : core_hash;

    always #5 clk = ~clk;

    miner_nonce_ctrl #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .ack(ack),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .finished(finished), .hash_in(hash_in), .hash_enable(hash_enable),
        .nonce(nonce), .busy(busy), .found(found), .golden_nonce(golden_nonce),
        .done(done), .timeout(timeout), .attempts(attempts)
    );

    typedef struct {
        logic          f;
        logic          d;
        logic          t;
        logic [NW-1:0] g;
        logic [NW-1:0] a;
    } res_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [NW-1:0] exp_nonce_q[$];
    res_t          exp_res_q[$];
    res_t          last_res;
    logic [NW-1:0] model_golden = '0;
    logic [HW-1:0] dig_tab[logic [NW-1:0]];
    bit            core_en = 1'b1;
    int            core_lat_min = 1;
    int            core_lat_max = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] digest_of(input logic [NW-1:0] n);
        if (dig_tab.exists(n)) return dig_tab[n];
        return '1;
    endfunction

    function automatic logic [HW-1:0] rand256();
        logic [HW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference search: walk the range with plain arithmetic until a hit or the last nonce.
    task automatic model_search(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [HW-1:0] t);
        logic [NW-1:0] n;
        int            att;
        res_t          r;
        n   = s;
        att = 0;
        forever begin
            exp_nonce_q.push_back(n);
            att++;
            if (digest_of(n) < t) begin
                model_golden = n;
                r.f = 1'b1; r.d = 1'b0; r.t = 1'b0; r.g = n; r.a = NW'(att);
                break;
            end
            if (n == e) begin
                r.f = 1'b0; r.d = 1'b1; r.t = 1'b0; r.g = model_golden; r.a = NW'(att);
                break;
            end
            n = n + NW'(1);
        end
        exp_res_q.push_back(r);
        last_res = r;
    endtask

    task automatic apply_stimulus(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [HW-1:0] t);
        @(negedge clk);
        nonce_start = s;
        nonce_end   = e;
        target      = t;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_result(input int bound);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (found || done || timeout) got = 1'b1;
        end
        check_output("result_within_bound", 256'(got), 256'(1));
    endtask

    task automatic hold_and_ack(input int hold);
        repeat (hold) @(negedge clk);
        check_output("hold_found", 256'(found), 256'(last_res.f));
        check_output("hold_done", 256'(done), 256'(last_res.d));
        check_output("hold_timeout", 256'(timeout), 256'(last_res.t));
        check_output("hold_golden", 256'(golden_nonce), 256'(last_res.g));
        check_output("hold_attempts", 256'(attempts), 256'(last_res.a));
        check_output("hold_busy", 256'(busy), 256'(0));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_output("ack_flags", 256'({found, done, timeout}), 256'(0));
        check_output("ack_busy", 256'(busy), 256'(0));
        check_output("pulses_consumed", 256'(exp_nonce_q.size()), 256'(0));
    endtask

    task automatic run_search(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [HW-1:0] t);
        model_search(s, e, t);
        apply_stimulus(s, e, t);
        wait_result(200);
        hold_and_ack(2);
    endtask

    // Core model: answers each hash request after a random latency with the table digest.
    initial begin
        int            lat;
        logic [NW-1:0] n;
        core_fin  = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            if (hash_enable && core_en) begin
                n   = nonce;
                lat = $urandom_range(core_lat_max, core_lat_min);
                repeat (lat) @(posedge clk);
                #1;
                core_fin  = 1'b1;
                core_hash = digest_of(n);
                @(posedge clk);
                #1;
                core_fin  = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT pulses hash_enable or raises a result flag.
    initial begin
        logic  prev_he;
        logic  prev_any;
        logic  any;
        bit    fin_pending;
        int    fin_cyc;
        int    he_cyc;
        res_t  r;
        prev_he     = 1'b0;
        prev_any    = 1'b0;
        fin_pending = 1'b0;
        fin_cyc     = 0;
        he_cyc      = 0;
        forever begin
            @(negedge clk);
            any = found | done | timeout;
            if (n_rst) begin
                if (hash_enable) begin
                    check_output("he_single_cycle", 256'(prev_he), 256'(0));
                    if (exp_nonce_q.size() == 0) begin
                        check_output("unexpected_he_nonce", 256'(nonce), 256'('1));
                    end else begin
                        check_output("issued_nonce", 256'(nonce), 256'(exp_nonce_q.pop_front()));
                    end
                    if (fin_pending) begin
                        check_output("reissue_latency", 256'(cyc - fin_cyc), 256'(2));
                        fin_pending = 1'b0;
                    end
                    he_cyc = cyc;
                end
                if (finished && busy) begin
                    fin_cyc     = cyc;
                    fin_pending = 1'b1;
                end
                if (any && !prev_any) begin
                    if (exp_res_q.size() == 0) begin
                        check_output("unexpected_result", 256'({found, done, timeout}), 256'(0));
                    end else begin
                        r = exp_res_q.pop_front();
                        check_output("res_found", 256'(found), 256'(r.f));
                        check_output("res_done", 256'(done), 256'(r.d));
                        check_output("res_timeout", 256'(timeout), 256'(r.t));
                        check_output("res_golden", 256'(golden_nonce), 256'(r.g));
                        check_output("res_attempts", 256'(attempts), 256'(r.a));
                    end
                    check_output("res_busy", 256'(busy), 256'(0));
                    if (timeout) begin
                        check_output("timeout_latency", 256'(cyc - he_cyc), 256'(TO + 2));
                    end else if (fin_pending) begin
                        check_output("result_latency", 256'(cyc - fin_cyc), 256'(2));
                        fin_pending = 1'b0;
                    end
                end
            end
            prev_he  = hash_enable;
            prev_any = any;
        end
    end

    initial begin
        #300000;
        n_fail++;
        $display("[TB] FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [NW-1:0] s;
        logic [NW-1:0] e;
        logic [HW-1:0] t;
        bit            reached;
        int            len;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        nonce_start = '0; nonce_end = '0; target = '0;
        man_fin = 1'b0; man_hash = '0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_output("rst_hash_enable", 256'(hash_enable), 256'(0));
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_flags", 256'({found, done, timeout}), 256'(0));
        check_output("rst_nonce", 256'(nonce), 256'(0));
        check_output("rst_golden", 256'(golden_nonce), 256'(0));
        check_output("rst_attempts", 256'(attempts), 256'(0));

        $display("[TB] single nonce hit");
        core_lat_min = 3; core_lat_max = 3;
        dig_tab.delete();
        dig_tab[32'd5] = '0;
        run_search(32'd5, 32'd5, '1);

        $display("[TB] equal digest is a miss");
        core_lat_min = 1; core_lat_max = 3;
        dig_tab.delete();
        dig_tab[32'h10] = 256'h100;
        dig_tab[32'h11] = 256'h100;
        dig_tab[32'h12] = 256'h0FF;
        run_search(32'h10, 32'h13, 256'h100);

        $display("[TB] wrapping range exhausts");
        dig_tab.delete();
        run_search(32'hFFFF_FFFE, 32'h0000_0001, '0);

        $display("[TB] watchdog");
        core_en = 1'b0;
        exp_nonce_q.push_back(32'h77);
        last_res.f = 1'b0; last_res.d = 1'b0; last_res.t = 1'b1;
        last_res.g = model_golden; last_res.a = '0;
        exp_res_q.push_back(last_res);
        apply_stimulus(32'h77, 32'h80, '1);
        wait_result(400);
        hold_and_ack(5);
        core_en = 1'b1;

        $display("[TB] abort in WAIT then late finished");
        dig_tab.delete();
        exp_nonce_q.push_back(32'h20);
        exp_nonce_q.push_back(32'h21);
        exp_nonce_q.push_back(32'h22);
        apply_stimulus(32'h20, 32'h30, '0);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (attempts == 32'd2) reached = 1'b1;
        end
        core_en = 1'b0;
        check_output("abort_setup_reached", 256'(reached), 256'(1));
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_busy", 256'(busy), 256'(0));
        check_output("abort_hash_enable", 256'(hash_enable), 256'(0));
        check_output("abort_nonce_hold", 256'(nonce), 256'(32'h22));
        check_output("abort_attempts_hold", 256'(attempts), 256'(2));
        man_hash = '0;
        man_fin  = 1'b1;
        @(negedge clk);
        man_fin  = 1'b0;
        repeat (2) @(negedge clk);
        check_output("late_fin_attempts", 256'(attempts), 256'(2));
        check_output("late_fin_flags", 256'({found, done, timeout}), 256'(0));
        check_output("late_fin_busy", 256'(busy), 256'(0));
        check_output("abort_pulses_consumed", 256'(exp_nonce_q.size()), 256'(0));
        core_en = 1'b1;

        $display("[TB] start and inputs ignored while busy");
        dig_tab.delete();
        model_search(32'h40, 32'h42, '0);
        apply_stimulus(32'h40, 32'h42, '0);
        repeat (2) @(negedge clk);
        nonce_start = 32'h99;
        nonce_end   = 32'h41;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        wait_result(200);
        hold_and_ack(2);

        $display("[TB] start with abort in IDLE");
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_output("start_abort_busy", 256'(busy), 256'(0));
        @(negedge clk);
        check_output("start_abort_he", 256'(hash_enable), 256'(0));

        $display("[TB] reset mid-WAIT");
        core_en = 1'b0;
        exp_nonce_q.push_back(32'h55);
        apply_stimulus(32'h55, 32'h60, '1);
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check_output("midrst_busy_he", 256'({busy, hash_enable}), 256'(0));
        check_output("midrst_flags", 256'({found, done, timeout}), 256'(0));
        check_output("midrst_nonce", 256'(nonce), 256'(0));
        check_output("midrst_golden", 256'(golden_nonce), 256'(0));
        check_output("midrst_attempts", 256'(attempts), 256'(0));
        model_golden = '0;
        n_rst   = 1'b1;
        core_en = 1'b1;

        $display("[TB] randomized searches");
        core_lat_min = 1; core_lat_max = 4;
        for (int k = 0; k < 20; k++) begin
            s = $urandom;
            if ($urandom_range(3, 0) == 0) s = 32'hFFFF_FFFF - NW'($urandom_range(3, 0));
            len = $urandom_range(6, 1);
            e = s + NW'(len - 1);
            t = rand256();
            if ($urandom_range(3, 0) == 0) t = {224'd0, t[31:0]};
            dig_tab.delete();
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(3, 0))
                    0: dig_tab[s + NW'(j)] = t;
                    1: dig_tab[s + NW'(j)] = (t == '0) ? '1 : t - 256'(1);
                    2: dig_tab[s + NW'(j)] = '1;
                    default: dig_tab[s + NW'(j)] = rand256();
                endcase
            end
            run_search(s, e, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
